// File: rtl/digi_ota_cal_ctrl.sv
// -----------------------------------------------------------------------------
// digi_ota_cal_ctrl
//
// Offset-calibration sequencer for the comparator-based OTA.
//
// When start_i is accepted, the block does the following:
//   1. It enables the OTA and shorts the OTA inputs.
//   2. It runs a successive-approximation search on the offset-trim code,
//      MSB first. The synchronised comparator output is the decision: 1 means
//      the trim is too high.
//   3. It releases the input short.
//   4. It keeps the OTA enabled in RUN with the resolved trim.
//
// Optional build macro: DIGI_OTA_CAL_MAJORITY_EN
//   Undefined : each bit decision uses a single comparator sample.
//   Defined   : DECIDE lasts 3 cycles, and the bit decision is the majority
//               of the 3 consecutive comparator samples.
//
// Parameters
//   TRIM_W      trim code width (2..8)
//   SETTLE_CYC  settle cycles before each decision (2..255). This also
//               covers the 2-flop comparator synchroniser.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   start_i     single-cycle calibration request (ignored while busy)
//   stop_i      return to IDLE and power down the OTA (wins over start_i)
//   cmp_in_i    asynchronous OTA comparator output
//   ota_en_o    OTA enable
//   short_en_o  input-short switch enable, only during calibration
//   trim_o      offset-trim code
//   busy_o      calibration in progress
//   done_o      one-cycle pulse on entry to RUN
//   cal_err_o   final trim saturated (all zeros or all ones); held until
//               the next accepted start or reset
//   state_o     current FSM state (0 IDLE, 1 SETTLE, 2 DECIDE, 3 RUN)
//
// Handshake: start_i and stop_i are level-sampled on every rising edge.
// start_i is accepted only in IDLE or RUN when stop_i is low. No
// acknowledge is returned; busy_o rises on the edge that accepts start_i.
// -----------------------------------------------------------------------------
module digi_ota_cal_ctrl #(
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              cmp_in_i,
  output logic              ota_en_o,
  output logic              short_en_o,
  output logic [TRIM_W-1:0] trim_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cal_err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DECIDE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int                PTR_W       = $clog2(TRIM_W);
  localparam logic [TRIM_W-1:0] MIDSCALE    = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [PTR_W-1:0]  PTR_MSB     = PTR_W'(TRIM_W-1);
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC-1);

  state_t              state_q, state_d;
  logic [TRIM_W-1:0]   trim_q, trim_d, trim_next;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                cal_err_q, cal_err_d;
  logic                sync1_q, cmp_s_q;

  // The bit decision, and whether this DECIDE cycle is the one that commits it.
  logic                decide_last;
  logic                decision;

`ifdef DIGI_OTA_CAL_MAJORITY_EN
  logic [1:0]          dec_cnt_q, dec_cnt_d;
  logic [1:0]          samp_q, samp_d;

  // The first two samples are stored. The third sample is cmp_s_q itself on
  // the committing cycle.
  assign decide_last = (dec_cnt_q == 2'd2);
  assign decision    = (samp_q[0] & samp_q[1]) | (samp_q[0] & cmp_s_q) |
                       (samp_q[1] & cmp_s_q);
`else
  assign decide_last = 1'b1;
  assign decision    = cmp_s_q;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      trim_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      cal_err_q <= 1'b0;
      sync1_q   <= 1'b0;
      cmp_s_q   <= 1'b0;
`ifdef DIGI_OTA_CAL_MAJORITY_EN
      dec_cnt_q <= '0;
      samp_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      trim_q    <= trim_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      cal_err_q <= cal_err_d;
      sync1_q   <= cmp_in_i;
      cmp_s_q   <= sync1_q;
`ifdef DIGI_OTA_CAL_MAJORITY_EN
      dec_cnt_q <= dec_cnt_d;
      samp_q    <= samp_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    trim_d    = trim_q;
    trim_next = trim_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    cal_err_d = cal_err_q;
`ifdef DIGI_OTA_CAL_MAJORITY_EN
    dec_cnt_d = dec_cnt_q;
    samp_d    = samp_q;
`endif

    if (stop_i) begin
      // trim and cal_err are deliberately retained across a stop.
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef DIGI_OTA_CAL_MAJORITY_EN
      dec_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (start_i) begin
            state_d   = ST_SETTLE;
            trim_d    = MIDSCALE;
            ptr_d     = PTR_MSB;
            cnt_d     = '0;
            cal_err_d = 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_DECIDE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_DECIDE: begin
          if (decide_last) begin
`ifdef DIGI_OTA_CAL_MAJORITY_EN
            dec_cnt_d = '0;
`endif
            if (decision) trim_next[ptr_q] = 1'b0;
            if (ptr_q != '0) begin
              trim_next[ptr_q - 1'b1] = 1'b1;
              ptr_d   = ptr_q - 1'b1;
              state_d = ST_SETTLE;
            end else begin
              state_d   = ST_RUN;
              done_d    = 1'b1;
              cal_err_d = (trim_next == '0) || (trim_next == '1);
            end
            trim_d = trim_next;
          end else begin
`ifdef DIGI_OTA_CAL_MAJORITY_EN
            samp_d[dec_cnt_q[0]] = cmp_s_q;
            dec_cnt_d            = dec_cnt_q + 2'd1;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    ota_en_o   = 1'b0;
    short_en_o = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      ST_SETTLE, ST_DECIDE: begin
        ota_en_o   = 1'b1;
        short_en_o = 1'b1;
        busy_o     = 1'b1;
      end
      ST_RUN:  ota_en_o = 1'b1;
      default: ;
    endcase
  end

  assign trim_o    = trim_q;
  assign done_o    = done_q;
  assign cal_err_o = cal_err_q;
  assign state_o   = state_q;

endmodule
